// File: rtl/nf_pkg.sv
// -----------------------------------------------------------------------------
// nf_pkg
// Definitions shared between the NAND controller and its page-dump streamer:
// default widths of the MCU-side RAM port, the RAM read latency, the skid
// FIFO depth, and the page-dump FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package nf_pkg;

   localparam int NF_ADDR_W = 15;  // MCU RAM address width
   localparam int NF_DATA_W = 8;   // RAM data / stream byte width
   localparam int NF_RD_LAT = 2;   // en_mcu sampled -> mcu_dataout valid
   localparam int NF_FIFO_D = 4;   // skid FIFO depth (>= RD_LAT+1, power of two)

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } nf_state_e;

endpackage

// File: rtl/nf_skid_fifo.sv
// -----------------------------------------------------------------------------
// nf_skid_fifo
// First-word-fall-through FIFO absorbing RAM returns while the downstream
// consumer applies backpressure. rd_data shows the head entry whenever
// empty is low; rd_en pops it.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous clear; wins over any write/read that cycle
//   wr_en       push wr_data (ignored when full)
//   wr_data     entry to push
//   rd_en       pop head (ignored when empty)
//   rd_data     head entry (valid while empty is low)
//   empty       no entries stored
//   count       number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module nf_skid_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // Simultaneous push and pop leave the occupancy unchanged.
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/nf_page_dump.sv
// -----------------------------------------------------------------------------
// nf_page_dump
// Reads `length` bytes starting at `base_addr` from the NAND controller's
// MCU-side page RAM and re-presents them as a byte stream with a last marker.
// Reads are only issued while the skid FIFO is guaranteed to have room for
// every read already in flight, so consumer backpressure never drops or
// duplicates a byte.
//
// Stream handshake: a byte transfers on a rising clk edge where m_valid and
// m_ready are both high. Once m_valid is raised, m_data/m_last stay stable
// until that transfer; m_valid never depends on m_ready. The only way a
// presented byte is withdrawn is abort or reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a dump (ignored while busy)
//   base_addr, length   first RAM address and byte count, sampled on start
//   abort               one-cycle pulse, terminates a dump at once
//   en_mcu, addr_mcu    RAM read request to the controller
//   mcu_dataout         RAM read data, RD_LAT cycles after the request
//   m_valid, m_data,
//   m_last, m_ready     output byte stream
//   busy                dump in progress
//   done                one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module nf_page_dump
   import nf_pkg::*;
#(
   parameter int ADDR_W = NF_ADDR_W,
   parameter int DATA_W = NF_DATA_W,
   parameter int RD_LAT = NF_RD_LAT,
   parameter int FIFO_D = NF_FIFO_D
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   input  logic              abort,
   output logic              en_mcu,
   output logic [ADDR_W-1:0] addr_mcu,
   input  logic [DATA_W-1:0] mcu_dataout,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   input  logic              m_ready,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(FIFO_D) + 1;
   localparam int OCC_W = CNT_W + 2;

   // FSM state, kept as a named signal for hierarchical observation.
   nf_state_e state;
   nf_state_e state_next;

   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W:0]   rem;        // reads still to be issued
   logic [RD_LAT-1:0] sr_valid;   // one bit per read in flight
   logic [RD_LAT-1:0] sr_last;    // travels with sr_valid: final read of dump
   logic [OCC_W-1:0]  inflight;
   logic [OCC_W-1:0]  occ;
   logic              credit_ok;
   logic              start_ok;
   logic              abort_ok;
   logic              issue;
   logic              final_issue;

   logic              fifo_wr;
   logic [DATA_W:0]   fifo_wdata;
   logic              fifo_pop;
   logic [DATA_W:0]   fifo_rdata;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   assign start_ok    = (state == ST_IDLE) && start;
   assign abort_ok    = (state != ST_IDLE) && abort;
   assign issue       = en_mcu;
   assign final_issue = issue && (rem == (ADDR_W+1)'(1));

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         inflight = inflight + OCC_W'(sr_valid[i]);
      end
   end

   // Every read counts against FIFO space from issue onwards, so a stalled
   // consumer can never cause a RAM return to find the FIFO full.
   assign occ       = OCC_W'(fifo_count) + inflight;
   assign credit_ok = (occ < OCC_W'(FIFO_D));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = (length == '0) ? ST_FINISH : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (final_issue) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Leave as the last byte is taken so done follows it by one cycle.
            if (abort) begin
               state_next = ST_IDLE;
            end else if ((sr_valid == '0) &&
                         ((fifo_count == '0) ||
                          ((fifo_count == CNT_W'(1)) && fifo_pop))) begin
               state_next = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      en_mcu = (state == ST_ISSUE) && credit_ok && !abort;
      busy   = (state != ST_IDLE);
      done   = (state == ST_FINISH);
   end

   // ---------------- address / count / in-flight tracking ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr <= '0;
         rem      <= '0;
         sr_valid <= '0;
         sr_last  <= '0;
      end else begin
         if (start_ok) begin
            cur_addr <= base_addr;
            rem      <= length;
         end else if (issue) begin
            cur_addr <= cur_addr + ADDR_W'(1);  // wraps at the top of RAM
            rem      <= rem - (ADDR_W+1)'(1);
         end

         // Clearing the pipe on abort discards RAM returns still on the way.
         if (abort_ok) begin
            sr_valid <= '0;
            sr_last  <= '0;
         end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
               sr_valid[i] <= sr_valid[i-1];
               sr_last[i]  <= sr_last[i-1];
            end
            sr_valid[0] <= issue;
            sr_last[0]  <= final_issue;
         end
      end
   end

   assign addr_mcu = cur_addr;

   // ---------------- skid FIFO ----------------
   assign fifo_wr    = sr_valid[RD_LAT-1];
   assign fifo_wdata = {sr_last[RD_LAT-1], mcu_dataout};
   assign fifo_pop   = m_ready && !fifo_empty;

   nf_skid_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_D)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (abort_ok),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_pop),
      .rd_data (fifo_rdata),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Stale storage is masked so the stream reads zero while empty.
   assign m_valid = !fifo_empty;
   assign m_data  = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
   assign m_last  = !fifo_empty && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_nf_page_dump.sv
// -----------------------------------------------------------------------------
// tb_nf_page_dump
// Bench for nf_page_dump: RAM model with fixed read latency, reference model
// of the expected address sequence and byte stream, and a negedge monitor
// that compares every RAM request and every accepted stream byte.
// -----------------------------------------------------------------------------
module tb_nf_page_dump;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;
   localparam int FIFO_D = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   length;
   logic              abort;
   logic              en_mcu;
   logic [ADDR_W-1:0] addr_mcu;
   logic [DATA_W-1:0] mcu_dataout;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic              m_ready;
   logic              busy;
   logic              done;

   nf_page_dump #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT),
      .FIFO_D (FIFO_D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .abort       (abort),
      .en_mcu      (en_mcu),
      .addr_mcu    (addr_mcu),
      .mcu_dataout (mcu_dataout),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_last      (m_last),
      .m_ready     (m_ready),
      .busy        (busy),
      .done        (done)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- RAM model ----------------
   function automatic logic [DATA_W-1:0] ram_byte(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ {1'b0, a[14:8]};
   endfunction

   logic [DATA_W-1:0] ram_pipe [RD_LAT];
   always @(posedge clk) begin
      ram_pipe[0] <= en_mcu ? ram_byte(addr_mcu) : 8'hEE;
      for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
   end
   assign mcu_dataout = ram_pipe[RD_LAT-1];

   // ---------------- consumer ready driver ----------------
   int ready_mode;  // 0: low, 1: high, 2: high 30% of cycles
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         default: m_ready = ($urandom_range(0, 9) < 3);
      endcase
   end

   // ---------------- scoreboard ----------------
   logic [DATA_W:0]   exp_q[$];       // {last, data}
   logic [ADDR_W-1:0] exp_addr_q[$];

   int              issued_cnt = 0;
   int              acc_cnt    = 0;
   int              done_cnt   = 0;
   logic            pend_done  = 1'b0;
   logic            stall_prev = 1'b0;
   logic [DATA_W:0] stall_val  = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         issued_cnt = 0;
         acc_cnt    = 0;
         pend_done  = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (pend_done) begin
            chk("done_after_last", done, 1);
            pend_done = 1'b0;
         end
         if (done) done_cnt++;
         if (!busy) begin
            issued_cnt = 0;
            acc_cnt    = 0;
         end
         if (stall_prev && m_valid) chk("hold_stable", {m_last, m_data}, stall_val);
         stall_prev = m_valid && !m_ready;
         stall_val  = {m_last, m_data};

         if (en_mcu) begin
            chk("credit_available", (issued_cnt - acc_cnt) < FIFO_D, 1);
            chk("issue_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) chk("addr_mcu", addr_mcu, exp_addr_q.pop_front());
            issued_cnt++;
         end
         if (m_valid && m_ready) begin
            chk("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               logic [DATA_W:0] e;
               e = exp_q.pop_front();
               chk("stream_byte", {m_last, m_data}, e);
               if (e[DATA_W]) pend_done = 1'b1;
            end
            acc_cnt++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 just after start was sampled.
   task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
      logic [ADDR_W-1:0] a;
      for (int i = 0; i < int'(n); i++) begin
         a = b + ADDR_W'(i);
         exp_addr_q.push_back(a);
         exp_q.push_back({(i == int'(n) - 1), ram_byte(a)});
      end
      base_addr = b;
      length    = n;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int k = 0;
      while (done_cnt == d0 && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({name, "_done_count"}, done_cnt - d0, 1);
      chk({name, "_drained"}, exp_q.size() + exp_addr_q.size(), 0);
      @(posedge clk);
      #1;
      chk({name, "_idle"}, busy, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d0;
      int k;
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      base_addr  = '0;
      length     = '0;
      ready_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en_mcu", en_mcu, 0);
      chk("rst_addr_mcu", addr_mcu, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic dump, full throughput
      ready_mode = 1;
      @(posedge clk);
      #1;
      d0 = done_cnt;
      do_start(15'h0000, 16);
      k = 0;
      while (!m_valid && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("first_valid_latency", k, RD_LAT + 1);
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("burst_cycles", k, 16);
      wait_done(d0, "basic");

      // Backpressure
      ready_mode = 2;
      d0 = done_cnt;
      do_start(15'h0100, 64);
      wait_done(d0, "backpressure");

      // Wrap at top of RAM; a start while busy must be ignored
      ready_mode = 1;
      d0 = done_cnt;
      do_start(15'h7FFE, 4);
      base_addr = 15'h1234;
      length    = 5;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d0, "wrap");

      // Zero length
      d0 = done_cnt;
      do_start(15'h0055, 0);
      chk("zero_busy", busy, 1);
      chk("zero_done", done, 1);
      chk("zero_m_valid", m_valid, 0);
      chk("zero_en_mcu", en_mcu, 0);
      @(posedge clk);
      #1;
      chk("zero_busy_after", busy, 0);
      chk("zero_done_after", done, 0);
      chk("zero_done_count", done_cnt - d0, 1);

      // Abort after 10 accepted bytes with the consumer stalled
      ready_mode = 1;
      d0 = done_cnt;
      do_start(15'h0300, 100);
      k = 0;
      while (acc_cnt < 10 && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
      ready_mode = 0;
      chk("abort_accepted", acc_cnt, 10);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
      chk("abort_m_valid", m_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_en_mcu", en_mcu, 0);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_stays_empty", m_valid, 0);
      ready_mode = 1;
      d0 = done_cnt;
      do_start(15'h0420, 20);
      wait_done(d0, "after_abort");

      // Randomized dumps
      for (int t = 0; t < 6; t++) begin
         ready_mode = $urandom_range(1, 2);
         d0 = done_cnt;
         do_start(ADDR_W'($urandom), (ADDR_W+1)'($urandom_range(1, 40)));
         wait_done(d0, "random");
      end

      // Asynchronous reset mid-dump
      ready_mode = 2;
      do_start(15'h0200, 50);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_en_mcu", en_mcu, 0);
      chk("arst_addr_mcu", addr_mcu, 0);
      chk("arst_m_valid", m_valid, 0);
      chk("arst_m_data", m_data, 0);
      chk("arst_m_last", m_last, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      exp_q.delete();
      exp_addr_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ready_mode = 1;
      d0 = done_cnt;
      do_start(15'h5A5A, 30);
      wait_done(d0, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
